// File: rtl/vcgrey_nre.sv
// vcgrey_nre: parametrised up/down Gray-code counter with parallel Gray load,
// asynchronous active-low clear, wrap/saturate mode, terminal count and cascade enable.
module vcgrey_nre #(
    parameter int unsigned WIDTH    = 4,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ce,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] B,
    output logic             TC,
    output logic             CEO
);
    logic [WIDTH-1:0] ld_bin;
    logic [WIDTH-1:0] nxt;

    // Binary bit i is the XOR of Gray bits [WIDTH-1:i].
    always_comb begin
        ld_bin = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            ld_bin[i] = ^(D >> i);
        end
    end

    always_comb begin
        TC  = up ? (B == '1) : (B == '0);
        CEO = ce & TC;
    end

    always_comb begin
        nxt = B;
        if (ld) begin
            nxt = ld_bin;
        end else if (ce && !(SATURATE && TC)) begin
            nxt = up ? B + 1'b1 : B - 1'b1;
        end
    end

    // Y is its own flop, encoded from the next state, so it never glitches through a decoder.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            B <= '0;
            Y <= '0;
        end else begin
            B <= nxt;
            Y <= nxt ^ (nxt >> 1);
        end
    end
endmodule

// File: tb/tb_vcgrey_nre.sv
// Scoreboard bench for vcgrey_nre: a wrapping and a saturating instance, directed vectors
// push expected outputs into a queue that a separate monitor pops and compares.
module tb_vcgrey_nre;
    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       ce  = 1'b1;
    logic       up  = 1'b1;
    logic       ld  = 1'b0;
    logic [3:0] D   = 4'b0000;
    logic [3:0] y0, b0, y1, b1;
    logic       tc0, ceo0, tc1, ceo1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         sel;
        logic [3:0] y;
        logic [3:0] b;
        logic       tc;
        logic       ceo;
        string      tag;
    } exp_t;

    exp_t q[$];
    event probe;

    logic [3:0] gray [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                              4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                              4'b1010, 4'b1011, 4'b1001, 4'b1000};

    vcgrey_nre #(.WIDTH(4), .SATURATE(1'b0)) dut0 (
        .clk(clk), .clr(clr), .ce(ce), .up(up), .ld(ld), .D(D),
        .Y(y0), .B(b0), .TC(tc0), .CEO(ceo0)
    );

    vcgrey_nre #(.WIDTH(4), .SATURATE(1'b1)) dut1 (
        .clk(clk), .clr(clr), .ce(ce), .up(up), .ld(ld), .D(D),
        .Y(y1), .B(b1), .TC(tc1), .CEO(ceo1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string fld, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got %b want %b at %0t", tag, fld, act, exp, $time);
        end
    endtask

    // Monitor: one expected entry per sampling point (clock edge or asynchronous probe).
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or probe);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.sel == 0) begin
                    chk(e.tag, "Y", y0, e.y);
                    chk(e.tag, "B", b0, e.b);
                    chk(e.tag, "TC", {3'b000, tc0}, {3'b000, e.tc});
                    chk(e.tag, "CEO", {3'b000, ceo0}, {3'b000, e.ceo});
                end else begin
                    chk(e.tag, "Y", y1, e.y);
                    chk(e.tag, "B", b1, e.b);
                    chk(e.tag, "TC", {3'b000, tc1}, {3'b000, e.tc});
                    chk(e.tag, "CEO", {3'b000, ceo1}, {3'b000, e.ceo});
                end
            end
        end
    end

    task automatic push(input int sel, input logic [3:0] ey, input logic [3:0] eb,
                        input logic etc, input logic eceo, input string tag);
        exp_t e;
        e.sel = sel; e.y = ey; e.b = eb; e.tc = etc; e.ceo = eceo; e.tag = tag;
        q.push_back(e);
    endtask

    // Drive inputs for one edge; expectation is the post-edge state with these inputs held.
    task automatic vec(input int sel, input logic c, input logic u, input logic l, input logic [3:0] d,
                       input logic [3:0] ey, input logic [3:0] eb, input logic etc, input logic eceo,
                       input string tag);
        @(negedge clk);
        ce = c; up = u; ld = l; D = d;
        push(sel, ey, eb, etc, eceo, tag);
    endtask

    task automatic probe_chk(input int sel, input logic [3:0] ey, input logic [3:0] eb,
                             input logic etc, input logic eceo, input string tag);
        push(sel, ey, eb, etc, eceo, tag);
        ->probe;
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b0; ce = 1'b0; ld = 1'b0; up = 1'b1;
        @(negedge clk);
        clr = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int m;
        // Reset held across edges with ce=1, up=1
        for (int k = 0; k < 3; k++) vec(0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'd0, 1'b0, 1'b0, "rst");
        vec(1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'd0, 1'b0, 1'b0, "rst_sat");
        @(negedge clk);
        clr = 1'b1; ce = 1'b0;

        // Full up-count with wrap
        vec(0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'd0, 1'b0, 1'b0, "up_start");
        for (int k = 1; k <= 16; k++) begin
            m = k % 16;
            vec(0, 1'b1, 1'b1, 1'b0, 4'b0000, gray[m], 4'(m), m == 15, m == 15, "up");
        end

        // Asynchronous clear mid-count at Y=0110
        do_reset();
        for (int k = 1; k <= 4; k++) vec(0, 1'b1, 1'b1, 1'b0, 4'b0000, gray[k], 4'(k), 1'b0, 1'b0, "pre_clr");
        @(negedge clk);
        #2 clr = 1'b0;
        probe_chk(0, 4'b0000, 4'd0, 1'b0, 1'b0, "async_clr");
        @(negedge clk);
        clr = 1'b1; ce = 1'b0;

        // Half-rate ce around the up terminal
        vec(0, 1'b0, 1'b1, 1'b1, 4'b1011, 4'b1011, 4'd13, 1'b0, 1'b0, "ld13");
        vec(0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1001, 4'd14, 1'b0, 1'b0, "half_ce1");
        vec(0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1001, 4'd14, 1'b0, 1'b0, "half_ce0");
        vec(0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1000, 4'd15, 1'b1, 1'b1, "half_tc_ce1");
        vec(0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1000, 4'd15, 1'b1, 1'b0, "half_tc_ce0");
        vec(0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'd0, 1'b0, 1'b0, "half_wrap");
        vec(0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'd0, 1'b0, 1'b0, "half_hold");

        // Load then count down through zero
        vec(0, 1'b0, 1'b1, 1'b1, 4'b0111, 4'b0111, 4'd5, 1'b0, 1'b0, "ld5");
        vec(0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0110, 4'd4, 1'b0, 1'b0, "dn4");
        vec(0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0010, 4'd3, 1'b0, 1'b0, "dn3");
        vec(0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0011, 4'd2, 1'b0, 1'b0, "dn2");
        vec(0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0001, 4'd1, 1'b0, 1'b0, "dn1");
        vec(0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'd0, 1'b1, 1'b1, "dn0");
        vec(0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000, 4'd15, 1'b0, 1'b0, "dn15");
        vec(0, 1'b1, 1'b0, 1'b1, 4'b1100, 4'b1100, 4'd8, 1'b0, 1'b0, "ld_wins");
        vec(0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'd0, 1'b1, 1'b1, "ld_tc_ceo");

        // Saturating instance
        do_reset();
        vec(1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'd0, 1'b0, 1'b0, "sat_start");
        for (int k = 1; k <= 20; k++) begin
            m = (k > 15) ? 15 : k;
            vec(1, 1'b1, 1'b1, 1'b0, 4'b0000, gray[m], 4'(m), m == 15, m == 15, "sat");
        end
        @(negedge clk);
        ce = 1'b0;
        probe_chk(1, 4'b1000, 4'd15, 1'b1, 1'b0, "sat_ce0");
        up = 1'b0;
        probe_chk(1, 4'b1000, 4'd15, 1'b0, 1'b0, "dir_tc");
        vec(1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1001, 4'd14, 1'b0, 1'b0, "sat_down");

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
